fib_access_arbiter: RTL and testbench
=====================================

Name: fib_access_arbiter

Overview:
- Shares the single FIB longest-prefix-match lookup port among NUM_REQ PIT/interface requesters.
- Round-robin arbitration, one lookup in flight at a time.
- Drives the FIB's prefix, length and fib_out_bit inputs, captures the result, and returns it to the granted requester only.
- Sits between the per-interface PIT instances and fib_table.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PREFIX_W, 64, prefix width.
- LEN_W, 6, prefix-length width.
- TIMEOUT_CYC, 64, cycles allowed in WAIT before a forced miss (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester lookup request; held until req_ready.
- req_prefix  in  NUM_REQ*PREFIX_W  packed prefixes; requester i at [i*PREFIX_W +: PREFIX_W].
- req_len  in  NUM_REQ*LEN_W  packed lengths, same packing.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- fib_prefix  out  PREFIX_W  to FIB pit_in_prefix.
- fib_len  out  LEN_W  to FIB pit_in_len.
- fib_start  out  1  to FIB fib_out_bit; one-cycle pulse.
- fib_lmp_prefix  in  PREFIX_W  FIB longest_matching_prefix.
- fib_lmp_len  in  LEN_W  FIB longest_matching_prefix_len.
- fib_lmp_valid  in  1  one-cycle strobe: FIB result valid.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- resp_prefix  out  PREFIX_W  matched prefix.
- resp_len  out  LEN_W  matched length; 0 means no match (broadcast/root).
- resp_timeout  out  1  high with resp_valid when the response was forced by timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, wait counter=0. All outputs, captured prefix/len and grant index are 0.
- Reset mid-operation aborts the in-flight lookup; no response is ever issued for it.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr_ptr upward with wrap.
  - At the clock edge: latch that requester's prefix/len and index g, then go to ISSUE.
  - If no request, stay in IDLE.
  - fib_lmp_valid is ignored in IDLE.
- ISSUE (1 cycle):
  - req_ready[g]=1 and fib_start=1.
  - fib_prefix/fib_len carry the latched values from ISSUE through WAIT; 0 in other states.
  - Next state: WAIT; counter cleared.
- WAIT:
  - On fib_lmp_valid, latch fib_lmp_prefix/len and go to RESP.
  - Otherwise increment the counter.
  - Length is passed through unmodified, including 0.
- RESP (1 cycle):
  - resp_valid[g]=1; resp_prefix/resp_len hold the latched values.
  - rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - Next state: IDLE.
- resp_prefix/resp_len/resp_timeout are 0 whenever resp_valid is all-zero.
- Latency: request seen in IDLE -> req_ready 1 cycle later. Response pulse comes 1 cycle after fib_lmp_valid.
- A new request can be accepted on the cycle after RESP. Back-to-back throughput: one lookup per (FIB latency + 3) cycles.
- Requests that drop req_valid before req_ready are simply not served.
- After req_ready, the granted requester's req_valid is ignored until the arbiter returns to IDLE.
- A requester may re-request immediately. Rotation still guarantees every other pending requester is served first.

Optional Feature:
- Macro FIB_ARB_TIMEOUT_EN.
- Defined:
  - If the counter reaches TIMEOUT_CYC-1 in WAIT without fib_lmp_valid, go to RESP.
  - Response is resp_prefix = captured request prefix, resp_len=0, resp_timeout=1.
  - If fib_lmp_valid arrives in the same cycle as expiry, the real result wins and resp_timeout=0.
  - A late fib_lmp_valid arriving after the forced response is ignored.
- Undefined: WAIT waits indefinitely, resp_timeout is tied to 0, and the counter logic is absent.

Decomposition:
- Package fib_pkg: PREFIX_W, LEN_W, arbiter state enum (IDLE/ISSUE/WAIT/RESP), NO_MATCH_LEN=0.
- One sub-module, rr_priority_picker.
  - Inputs: NUM_REQ request vector and pointer.
  - Outputs: one-hot grant, index and any-valid flag.
  - Purely combinational; reusable for later PIT/CS arbiters.

Test Plan:
- Single requester: req_valid[1]=1, prefix 0xA5, len 12. Expect req_ready[1] next cycle and one fib_start pulse. FIB returns (0xA5, 8) after 3 cycles; expect resp_valid=0b0010 with prefix 0xA5, len 8.
- Contention: req 0,2,3 asserted together from reset. Service order is 0,2,3. rr_ptr ends at 0, and no requester is granted twice.
- Fairness/wrap: all 4 continuously requesting for 8 lookups. Grant order is 0,1,2,3,0,1,2,3.
- No-match pass-through: FIB returns len 0. Expect resp_len=0, resp_timeout=0.
- Timeout (macro on, TIMEOUT_CYC=8): FIB never answers. Expect resp_valid 8 cycles into WAIT with resp_len=0 and resp_timeout=1. A late fib_lmp_valid afterwards must produce no response.
- Reset in WAIT:
  - Assert rst; all outputs go to 0 asynchronously.
  - After release, a stale fib_lmp_valid yields no resp_valid.
  - The next request is granted with rr_ptr=0.

Source files
------------

// File: rtl/fib_pkg.sv
// fib_pkg -- shared types and constants for the FIB access arbiter and the
// PIT/CS arbiters that will reuse its priority picker.
//   PREFIX_W      default name-prefix width
//   LEN_W         default prefix-length width
//   NO_MATCH_LEN  prefix length reported for "no match" (broadcast/root)
//   arb_state_e   arbiter sequence IDLE -> ISSUE -> WAIT -> RESP
package fib_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;

  localparam int NO_MATCH_LEN = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fib_access_arbiter_picker.sv
// rr_priority_picker -- combinational round-robin priority picker.
// Returns the first set request bit found searching upward from ptr_i,
// wrapping past NUM_REQ-1 back to 0.
//   req_i    request vector
//   ptr_i    search start index (0..NUM_REQ-1)
//   grant_o  one-hot grant, all-zero when nothing is requested
//   idx_o    binary index of the granted bit (0 when nothing is requested)
//   any_o    at least one request bit is set
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    idx_o   = '0;
    grant_o = '0;
    any_o   = |req_i;
    // Scan from the farthest offset down to offset 0 so that the candidate
    // closest to the pointer is the last one written and therefore wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin : scan
      int cand;
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_i[cand]) idx_o = IDX_W'(cand);
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fib_access_arbiter.sv
// fib_access_arbiter -- shares the single FIB longest-prefix-match port among
// NUM_REQ PIT/interface requesters, round-robin, one lookup in flight.
// Optional build macro: FIB_ARB_TIMEOUT_EN -- forces a "no match" response
// (resp_len=0, resp_timeout=1) after TIMEOUT_CYC cycles in WAIT.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_prefix/req_len  per-requester lookup requests (packed)
//   req_ready                     one-hot acceptance pulse (ISSUE)
//   fib_prefix/fib_len/fib_start  lookup drive toward fib_table
//   fib_lmp_prefix/len/valid      lookup result from fib_table
//   resp_valid/prefix/len         one-hot response pulse plus result (RESP)
//   resp_timeout                  response was forced by the timeout
//   busy                          arbiter is not IDLE
module fib_access_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PREFIX_W    = fib_pkg::PREFIX_W,
  parameter int LEN_W       = fib_pkg::LEN_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*PREFIX_W-1:0] req_prefix,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [PREFIX_W-1:0]         fib_prefix,
  output logic [LEN_W-1:0]            fib_len,
  output logic                        fib_start,
  input  logic [PREFIX_W-1:0]         fib_lmp_prefix,
  input  logic [LEN_W-1:0]            fib_lmp_len,
  input  logic                        fib_lmp_valid,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [PREFIX_W-1:0]         resp_prefix,
  output logic [LEN_W-1:0]            resp_len,
  output logic                        resp_timeout,
  output logic                        busy
);

  import fib_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [PREFIX_W-1:0] prefix_q, prefix_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [PREFIX_W-1:0] res_prefix_q, res_prefix_d;
  logic [LEN_W-1:0]    res_len_q, res_len_d;

  logic [NUM_REQ-1:0]  pick_grant_unused;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_to_q, res_to_d;
`else
  // TIMEOUT_CYC only matters in the timeout build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant_unused),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      prefix_q     <= '0;
      len_q        <= '0;
      res_prefix_q <= '0;
      res_len_q    <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      res_to_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      prefix_q     <= prefix_d;
      len_q        <= len_d;
      res_prefix_q <= res_prefix_d;
      res_len_q    <= res_len_d;
`ifdef FIB_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      res_to_q     <= res_to_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    prefix_d     = prefix_q;
    len_d        = len_q;
    res_prefix_d = res_prefix_q;
    res_len_d    = res_len_q;
`ifdef FIB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    res_to_d     = res_to_q;
`endif
    case (state_q)
      IDLE: begin
        // The picker only matters here, so a granted requester that keeps
        // req_valid high cannot be re-picked before the arbiter is IDLE again.
        if (pick_any) begin
          grant_d  = pick_idx;
          prefix_d = req_prefix[pick_idx*PREFIX_W +: PREFIX_W];
          len_d    = req_len[pick_idx*LEN_W +: LEN_W];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FIB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // A real result always beats a simultaneous expiry.
        if (fib_lmp_valid) begin
          res_prefix_d = fib_lmp_prefix;
          res_len_d    = fib_lmp_len;
`ifdef FIB_ARB_TIMEOUT_EN
          res_to_d     = 1'b0;
`endif
          state_d      = RESP;
        end
`ifdef FIB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          res_prefix_d = prefix_q;
          res_len_d    = LEN_W'(NO_MATCH_LEN);
          res_to_d     = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so an asynchronous reset
  // clears every one of them immediately.
  always_comb begin
    req_ready    = '0;
    fib_start    = 1'b0;
    fib_prefix   = '0;
    fib_len      = '0;
    resp_valid   = '0;
    resp_prefix  = '0;
    resp_len     = '0;
    resp_timeout = 1'b0;
    case (state_q)
      ISSUE: begin
        req_ready[grant_q] = 1'b1;
        fib_start          = 1'b1;
        fib_prefix         = prefix_q;
        fib_len            = len_q;
      end
      WAIT: begin
        fib_prefix = prefix_q;
        fib_len    = len_q;
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        resp_prefix         = res_prefix_q;
        resp_len            = res_len_q;
`ifdef FIB_ARB_TIMEOUT_EN
        resp_timeout        = res_to_q;
`endif
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fib_access_arbiter.sv
module tb_fib_access_arbiter;

  localparam int NR = 4;
  localparam int PW = 64;
  localparam int LW = 6;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*PW-1:0] req_prefix;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]    req_ready;
  logic [PW-1:0]    fib_prefix;
  logic [LW-1:0]    fib_len;
  logic             fib_start;
  logic [PW-1:0]    fib_lmp_prefix;
  logic [LW-1:0]    fib_lmp_len;
  logic             fib_lmp_valid;
  logic [NR-1:0]    resp_valid;
  logic [PW-1:0]    resp_prefix;
  logic [LW-1:0]    resp_len;
  logic             resp_timeout;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;

  fib_access_arbiter #(
    .NUM_REQ     (NR),
    .PREFIX_W    (PW),
    .LEN_W       (LW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_prefix     (req_prefix),
    .req_len        (req_len),
    .req_ready      (req_ready),
    .fib_prefix     (fib_prefix),
    .fib_len        (fib_len),
    .fib_start      (fib_start),
    .fib_lmp_prefix (fib_lmp_prefix),
    .fib_lmp_len    (fib_lmp_len),
    .fib_lmp_valid  (fib_lmp_valid),
    .resp_valid     (resp_valid),
    .resp_prefix    (resp_prefix),
    .resp_len       (resp_len),
    .resp_timeout   (resp_timeout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (fib_start) start_cnt++;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [63:0] oh(input int g);
    logic [63:0] v;
    v = 64'd1 << g;
    return v;
  endfunction

  task automatic set_req(input int g, input logic [PW-1:0] p, input logic [LW-1:0] l);
    req_valid[g] = 1'b1;
    req_prefix[g*PW +: PW] = p;
    req_len[g*LW +: LW] = l;
  endtask

  // Called on an IDLE negedge with requests set up. Waits (bounded) for the
  // grant, checks the issue cycle, answers after `lat` WAIT cycles with
  // (rp, rl), checks the response and returns on the next IDLE negedge.
  task automatic serve(input int g, input logic [PW-1:0] ip, input logic [LW-1:0] il,
                       input logic [PW-1:0] rp, input logic [LW-1:0] rl,
                       input int lat, input bit drop);
    int n;
    n = 0;
    while (req_ready == '0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_vec($sformatf("ready_g%0d", g), 64'(req_ready), oh(g));
    check_vec("fib_start", 64'(fib_start), 64'd1);
    check_vec("fib_prefix", 64'(fib_prefix), 64'(ip));
    check_vec("fib_len", 64'(fib_len), 64'(il));
    if (drop) req_valid[g] = 1'b0;
    repeat (lat) @(negedge clk);
    fib_lmp_valid  = 1'b1;
    fib_lmp_prefix = rp;
    fib_lmp_len    = rl;
    @(negedge clk);
    fib_lmp_valid = 1'b0;
    check_vec($sformatf("resp_valid_g%0d", g), 64'(resp_valid), oh(g));
    check_vec("resp_prefix", 64'(resp_prefix), 64'(rp));
    check_vec("resp_len", 64'(resp_len), 64'(rl));
    check_vec("resp_timeout", 64'(resp_timeout), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_prefix = '0;
    req_len = '0;
    fib_lmp_valid = 1'b0;
    fib_lmp_prefix = '0;
    fib_lmp_len = '0;
    repeat (2) @(negedge clk);
    check_vec("rst_busy", 64'(busy), 64'd0);
    check_vec("rst_ready", 64'(req_ready), 64'd0);
    check_vec("rst_resp", 64'(resp_valid), 64'd0);
    check_vec("rst_fibpfx", 64'(fib_prefix), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester 1, FIB answers (0xA5, 8) after 3 WAIT cycles.
    start_cnt = 0;
    set_req(1, 64'hA5, 6'd12);
    serve(1, 64'hA5, 6'd12, 64'hA5, 6'd8, 3, 1'b1);
    check_vec("start_pulses", 64'(start_cnt), 64'd1);
    check_vec("idle_resp_zero", 64'(resp_prefix), 64'd0);
    check_vec("idle_busy", 64'(busy), 64'd0);

    // Contention from reset: 0,2,3 together -> served 0,2,3.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 64'h100, 6'd10);
    set_req(2, 64'h300, 6'd30);
    set_req(3, 64'h400, 6'd40);
    serve(0, 64'h100, 6'd10, 64'h10, 6'd4, 1, 1'b1);
    serve(2, 64'h300, 6'd30, 64'h30, 6'd5, 2, 1'b1);
    serve(3, 64'h400, 6'd40, 64'h40, 6'd6, 1, 1'b1);
    repeat (2) @(negedge clk);
    check_vec("no_regrant", 64'(req_ready), 64'd0);
    check_vec("cont_idle", 64'(busy), 64'd0);
    // Pointer wrapped to 0: with 0 and 1 both pending, 0 wins.
    set_req(1, 64'h200, 6'd20);
    set_req(0, 64'h101, 6'd11);
    serve(0, 64'h101, 6'd11, 64'h1, 6'd1, 1, 1'b1);
    serve(1, 64'h200, 6'd20, 64'h2, 6'd2, 1, 1'b1);

    // Fairness: all four held high for 8 lookups, pointer starts at 2.
    for (int g = 0; g < NR; g++) set_req(g, 64'(64'hF000 + g), 6'(g + 1));
    for (int k = 0; k < 8; k++) begin
      int g;
      g = (k + 2) % NR;
      serve(g, 64'(64'hF000 + g), 6'(g + 1), 64'(64'hE000 + k), 6'(k + 1), 1, 1'b0);
    end
    req_valid = '0;

    // No-match pass-through: length 0 returned unchanged (pointer now 2).
    set_req(2, 64'hBEEF, 6'd24);
    serve(2, 64'hBEEF, 6'd24, 64'h0, 6'd0, 2, 1'b1);

`ifdef FIB_ARB_TIMEOUT_EN
    // FIB never answers: forced response after 8 WAIT cycles.
    set_req(3, 64'hCAFE, 6'd33);
    n = 0;
    while (req_ready == '0 && n < 8) begin @(negedge clk); n++; end
    check_vec("to_ready", 64'(req_ready), oh(3));
    req_valid[3] = 1'b0;
    n = 0;
    while (resp_valid == '0 && n < 20) begin @(negedge clk); n++; end
    // 8 negedges in WAIT (count 0..7), RESP on the 9th.
    check_vec("to_cycles", 64'(n), 64'd9);
    check_vec("to_resp_valid", 64'(resp_valid), oh(3));
    check_vec("to_resp_prefix", 64'(resp_prefix), 64'hCAFE);
    check_vec("to_resp_len", 64'(resp_len), 64'd0);
    check_vec("to_flag", 64'(resp_timeout), 64'd1);
    @(negedge clk);
    fib_lmp_valid = 1'b1;
    fib_lmp_prefix = 64'h77;
    fib_lmp_len = 6'd7;
    @(negedge clk);
    fib_lmp_valid = 1'b0;
    check_vec("late_ignored", 64'(resp_valid), 64'd0);
    check_vec("late_busy", 64'(busy), 64'd0);
    // Result arriving on the expiry cycle wins (pointer now 0).
    set_req(0, 64'hD00D, 6'd9);
    @(negedge clk);
    check_vec("tie_ready", 64'(req_ready), oh(0));
    req_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    fib_lmp_valid = 1'b1;
    fib_lmp_prefix = 64'h55;
    fib_lmp_len = 6'd5;
    @(negedge clk);
    fib_lmp_valid = 1'b0;
    check_vec("tie_valid", 64'(resp_valid), oh(0));
    check_vec("tie_len", 64'(resp_len), 64'd5);
    check_vec("tie_flag", 64'(resp_timeout), 64'd0);
    @(negedge clk);
`else
    // Without the timeout build WAIT holds until the FIB answers.
    set_req(3, 64'hCAFE, 6'd33);
    @(negedge clk);
    check_vec("hold_ready", 64'(req_ready), oh(3));
    req_valid[3] = 1'b0;
    repeat (30) @(negedge clk);
    check_vec("hold_busy", 64'(busy), 64'd1);
    check_vec("hold_noresp", 64'(resp_valid), 64'd0);
    fib_lmp_valid = 1'b1;
    fib_lmp_prefix = 64'h66;
    fib_lmp_len = 6'd6;
    @(negedge clk);
    fib_lmp_valid = 1'b0;
    check_vec("hold_resp", 64'(resp_valid), oh(3));
    check_vec("hold_flag", 64'(resp_timeout), 64'd0);
    @(negedge clk);
`endif

    // Reset in WAIT: serve 1 so the pointer moves to 2, then abort a lookup.
    set_req(1, 64'h1111, 6'd1);
    serve(1, 64'h1111, 6'd1, 64'h11, 6'd1, 1, 1'b1);
    set_req(2, 64'h2222, 6'd2);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    check_vec("pre_rst_wait", 64'(fib_prefix), 64'h2222);
    #2 rst = 1'b1;
    #1;
    check_vec("arst_busy", 64'(busy), 64'd0);
    check_vec("arst_fibpfx", 64'(fib_prefix), 64'd0);
    check_vec("arst_fiblen", 64'(fib_len), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fib_lmp_valid = 1'b1;
    fib_lmp_prefix = 64'h99;
    fib_lmp_len = 6'd9;
    @(negedge clk);
    fib_lmp_valid = 1'b0;
    check_vec("stale_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check_vec("stale_resp2", 64'(resp_valid), 64'd0);
    // Pointer back at 0: with 3 and 0 pending, 0 is granted.
    set_req(3, 64'h3333, 6'd3);
    set_req(0, 64'h4444, 6'd4);
    serve(0, 64'h4444, 6'd4, 64'h44, 6'd4, 1, 1'b1);
    serve(3, 64'h3333, 6'd3, 64'h33, 6'd3, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
